// File: rtl/toe_pkg.sv
// Shared TOE receive-path types: request codes, parser states, TCP flag
// positions, header word indices and the connection tuple.
package toe_pkg;

    typedef enum logic [1:0] {
        RQ_NONE   = 2'b00,
        RQ_LOOKUP = 2'b01,
        RQ_OPEN   = 2'b10,
        RQ_CLOSE  = 2'b11
    } rq_t;

    typedef enum logic [2:0] {
        HP_IDLE,
        HP_HDR,
        HP_REQ,
        HP_DRAIN,
        HP_DROP
    } hp_state_t;

    // TCP flag bit positions within the flags byte
    localparam int unsigned FLAG_FIN = 0;
    localparam int unsigned FLAG_SYN = 1;
    localparam int unsigned FLAG_RST = 2;
    localparam int unsigned FLAG_ACK = 4;

    // Header word index of each field (32-bit words from the frame start)
    localparam logic [3:0] W_MAC_DST_HI = 4'd0;
    localparam logic [3:0] W_MAC_DST_LO = 4'd1;
    localparam logic [3:0] W_MAC_SRC    = 4'd2;
    localparam logic [3:0] W_ETYPE      = 4'd3;
    localparam logic [3:0] W_PROTO      = 4'd5;
    localparam logic [3:0] W_IP_SRC_HI  = 4'd6;
    localparam logic [3:0] W_IP_SRC_LO  = 4'd7;
    localparam logic [3:0] W_IP_DST_HI  = 4'd7;
    localparam logic [3:0] W_IP_DST_LO  = 4'd8;
    localparam logic [3:0] W_PORT_SRC   = 4'd8;
    localparam logic [3:0] W_PORT_DST   = 4'd9;
    localparam logic [3:0] W_FLAGS      = 4'd11;

    // IPv4 with a 20-byte header; anything else carries options
    localparam logic [7:0] VER_IHL_NO_OPT = 8'h45;

    typedef struct packed {
        logic [23:0] mac_src;
        logic [23:0] mac_dst;
        logic [31:0] ip_src;
        logic [31:0] ip_dst;
        logic [15:0] port_src;
        logic [15:0] port_dst;
    } tuple_t;

    // RST/FIN close the connection first; a bare SYN opens one
    function automatic rq_t classify_flags(input logic [7:0] flags);
        if (flags[FLAG_RST] || flags[FLAG_FIN]) begin
            return RQ_CLOSE;
        end else if (flags[FLAG_SYN] && !flags[FLAG_ACK]) begin
            return RQ_OPEN;
        end else begin
            return RQ_LOOKUP;
        end
    endfunction

endpackage

// File: rtl/tcp_hdr_field_capture.sv
// Header word decoder: stores tuple fields by word index and flags any
// header word that fails the EtherType, version/IHL or protocol check.
module tcp_hdr_field_capture
    import toe_pkg::*;
#(
    parameter logic [15:0] ETHERTYPE_IPV4 = 16'h0800,
    parameter logic [7:0]  TCP_PROTO      = 8'd6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cap_en,
    input  logic [3:0]  cap_idx,
    input  logic [31:0] data,
    output tuple_t      tuple,
    output logic        field_err
);

    // Field registers, loaded from the word whose index owns each slice
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tuple <= '0;
        end else if (cap_en) begin
            if (cap_idx == W_MAC_DST_HI) tuple.mac_dst[23:16] <= data[7:0];
            if (cap_idx == W_MAC_DST_LO) tuple.mac_dst[15:0]  <= data[31:16];
            if (cap_idx == W_MAC_SRC)    tuple.mac_src        <= data[23:0];
            if (cap_idx == W_IP_SRC_HI)  tuple.ip_src[31:16]  <= data[15:0];
            if (cap_idx == W_IP_SRC_LO)  tuple.ip_src[15:0]   <= data[31:16];
            if (cap_idx == W_IP_DST_HI)  tuple.ip_dst[31:16]  <= data[15:0];
            if (cap_idx == W_IP_DST_LO)  tuple.ip_dst[15:0]   <= data[31:16];
            if (cap_idx == W_PORT_SRC)   tuple.port_src       <= data[15:0];
            if (cap_idx == W_PORT_DST)   tuple.port_dst       <= data[31:16];
        end
    end

    // Per-word header sanity check on the word currently presented
    always_comb begin
        field_err = 1'b0;
        if (cap_idx == W_ETYPE &&
            (data[31:16] != ETHERTYPE_IPV4 || data[15:8] != VER_IHL_NO_OPT)) begin
            field_err = 1'b1;
        end
        if (cap_idx == W_PROTO && data[7:0] != TCP_PROTO) begin
            field_err = 1'b1;
        end
    end

endmodule

// File: rtl/tcp_hdr_parser.sv
// Ethernet/IPv4/TCP header parser: extracts the connection tuple, classifies
// the segment and holds one request per good frame until the searcher is done.
module tcp_hdr_parser
    import toe_pkg::*;
#(
    parameter logic [15:0] ETHERTYPE_IPV4 = 16'h0800,
    parameter logic [7:0]  TCP_PROTO      = 8'd6,
    parameter int unsigned DROP_CNT_W     = 16
) (
    input  logic                  hp_clk,
    input  logic                  hp_rst,
    input  logic [31:0]           hp_in_data,
    input  logic                  hp_in_valid,
    input  logic                  hp_in_sop,
    input  logic                  hp_in_eop,
    output logic                  hp_in_ready,
    output logic [1:0]            hp_rq,
    output logic [7:0]            hp_id_in,
    output logic [23:0]           hp_mac_src,
    output logic [23:0]           hp_mac_dst,
    output logic [31:0]           hp_ip_src,
    output logic [31:0]           hp_ip_dst,
    output logic [15:0]           hp_port_src,
    output logic [15:0]           hp_port_dst,
    input  logic                  hp_rs_done,
    input  logic [7:0]            hp_rs_error,
    input  logic [7:0]            hp_rs_id_out,
    output logic [7:0]            hp_conn_id,
    output logic [7:0]            hp_conn_err,
    output logic                  hp_conn_valid,
    output logic [DROP_CNT_W-1:0] hp_drop_cnt
);

    hp_state_t state, state_nxt;
    rq_t       rq_q, rq_nxt;
    logic [3:0] word_idx, idx_nxt;
    logic       drain_pend, drain_nxt;
    logic [1:0] drop_add;
    logic       rs_take;
    logic       cap_en;
    logic [3:0] cap_idx;
    logic       field_err;
    logic       accept;
    tuple_t     tuple;
    logic [DROP_CNT_W:0]   drop_sum;
    logic [DROP_CNT_W-1:0] drop_nxt;

    assign accept  = hp_in_valid && hp_in_ready;
    assign cap_idx = hp_in_sop ? W_MAC_DST_HI : word_idx;

    tcp_hdr_field_capture #(
        .ETHERTYPE_IPV4 (ETHERTYPE_IPV4),
        .TCP_PROTO      (TCP_PROTO)
    ) u_capture (
        .clk       (hp_clk),
        .rst_n     (hp_rst),
        .cap_en    (cap_en),
        .cap_idx   (cap_idx),
        .data      (hp_in_data),
        .tuple     (tuple),
        .field_err (field_err)
    );

    assign hp_rq       = rq_q;
    assign hp_mac_src  = tuple.mac_src;
    assign hp_mac_dst  = tuple.mac_dst;
    assign hp_ip_src   = tuple.ip_src;
    assign hp_ip_dst   = tuple.ip_dst;
    assign hp_port_src = tuple.port_src;
    assign hp_port_dst = tuple.port_dst;

    // Next-state, capture and drop-count decisions for each accepted word
    always_comb begin
        state_nxt   = state;
        idx_nxt     = word_idx;
        drain_nxt   = drain_pend;
        rq_nxt      = rq_q;
        drop_add    = 2'd0;
        rs_take     = 1'b0;
        cap_en      = 1'b0;
        hp_in_ready = (state != HP_REQ);
        case (state)
            HP_IDLE: begin
                if (accept && hp_in_sop) begin
                    cap_en = 1'b1;
                    if (hp_in_eop) begin
                        drop_add = 2'd1;
                    end else begin
                        state_nxt = HP_HDR;
                        idx_nxt   = 4'd1;
                    end
                end
            end
            HP_HDR: begin
                if (accept) begin
                    cap_en = 1'b1;
                    if (hp_in_sop) begin
                        // abandoned header counts once; a one-word new frame counts too
                        if (hp_in_eop) begin
                            drop_add  = 2'd2;
                            state_nxt = HP_IDLE;
                        end else begin
                            drop_add = 2'd1;
                            idx_nxt  = 4'd1;
                        end
                    end else if (field_err) begin
                        drop_add  = 2'd1;
                        state_nxt = hp_in_eop ? HP_IDLE : HP_DROP;
                    end else if (word_idx == W_FLAGS) begin
                        rq_nxt    = classify_flags(hp_in_data[7:0]);
                        drain_nxt = !hp_in_eop;
                        state_nxt = HP_REQ;
                    end else if (hp_in_eop) begin
                        drop_add  = 2'd1;
                        state_nxt = HP_IDLE;
                    end else begin
                        idx_nxt = word_idx + 4'd1;
                    end
                end
            end
            HP_REQ: begin
                if (hp_rs_done) begin
                    rs_take   = 1'b1;
                    rq_nxt    = RQ_NONE;
                    drain_nxt = 1'b0;
                    state_nxt = drain_pend ? HP_DRAIN : HP_IDLE;
                end
            end
            HP_DRAIN, HP_DROP: begin
                // DROP was already counted on entry, DRAIN had its request
                if (accept) begin
                    if (hp_in_sop) begin
                        cap_en = 1'b1;
                        if (hp_in_eop) begin
                            drop_add  = 2'd1;
                            state_nxt = HP_IDLE;
                        end else begin
                            state_nxt = HP_HDR;
                            idx_nxt   = 4'd1;
                        end
                    end else if (hp_in_eop) begin
                        state_nxt = HP_IDLE;
                    end
                end
            end
            default: state_nxt = HP_IDLE;
        endcase
    end

    // Saturating drop counter increment
    always_comb begin
        drop_sum = {1'b0, hp_drop_cnt} + {{(DROP_CNT_W-1){1'b0}}, drop_add};
        drop_nxt = drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
    end

    // State, request and result registers
    always_ff @(posedge hp_clk or negedge hp_rst) begin
        if (!hp_rst) begin
            state         <= HP_IDLE;
            word_idx      <= '0;
            drain_pend    <= 1'b0;
            rq_q          <= RQ_NONE;
            hp_id_in      <= '0;
            hp_conn_id    <= '0;
            hp_conn_err   <= '0;
            hp_conn_valid <= 1'b0;
            hp_drop_cnt   <= '0;
        end else begin
            state         <= state_nxt;
            word_idx      <= idx_nxt;
            drain_pend    <= drain_nxt;
            rq_q          <= rq_nxt;
            hp_conn_valid <= rs_take;
            hp_drop_cnt   <= drop_nxt;
            if (rs_take) begin
                hp_conn_id  <= hp_rs_id_out;
                hp_conn_err <= hp_rs_error;
                hp_id_in    <= hp_id_in + 8'd1;
            end
        end
    end

endmodule
